inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 25 ++
 rtl/inst_fetch_if.sv | 32 +++
 rtl/inst_fetch.sv | 144 ++++++++++++++
 tb/tb_inst_fetch.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// ----------------------------------------------------------------------------
// riscv_defs: definitions shared across the fetch slice.
//   ADDR_W / INST_W : address and instruction widths
//   STALL_W         : width of the stall-control vector
//   STALL_IF        : stall vector bit that holds the IF stage
//   fetch_state_t   : byte-serial fetch FSM encoding
// ----------------------------------------------------------------------------
package riscv_defs;

   localparam int ADDR_W   = 32;
   localparam int INST_W   = 32;
   localparam int STALL_W  = 6;
   localparam int STALL_IF = 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD0  = 3'd1,
      RD1  = 3'd2,
      RD2  = 3'd3,
      RD3  = 3'd4,
      LAST = 3'd5,
      HOLD = 3'd6
   } fetch_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// ----------------------------------------------------------------------------
// inst_fetch_if: byte-wide read port between instruction fetch and the
// memory controller.
//   mem_grant_in  : controller grant, sampled by fetch only while idle
//   mem_din_in    : read byte, valid one cycle after its address
//   mem_a_out     : byte address
//   mem_rd_en_out : byte read request
// master = fetch side, slave = memory-controller side.
// ----------------------------------------------------------------------------
interface inst_fetch_if;
   import riscv_defs::*;

   logic              mem_grant_in;
   logic [7:0]        mem_din_in;
   logic [ADDR_W-1:0] mem_a_out;
   logic              mem_rd_en_out;

   modport master (
      input  mem_grant_in,
      input  mem_din_in,
      output mem_a_out,
      output mem_rd_en_out
   );

   modport slave (
      output mem_grant_in,
      output mem_din_in,
      input  mem_a_out,
      input  mem_rd_en_out
   );

endinterface

// File: rtl/inst_fetch.sv
// ----------------------------------------------------------------------------
// inst_fetch: fetches a 32-bit instruction as four little-endian byte reads.
//
// Ports
//   clk_in         : clock, rising edge
//   rst_in         : synchronous active-high reset (wins over rdy_in)
//   rdy_in         : global enable, 0 freezes all state
//   pc_in          : fetch address, latched when a fetch is accepted
//   branch_or_not  : redirect, abandons the current fetch
//   stall_in       : stall vector, bit STALL_IF holds a finished instruction
//   mem            : byte read port (inst_fetch_if.master)
//   stallreq_out   : high until an instruction is waiting in HOLD
//   inst_out       : assembled instruction
//   inst_pc_out    : address of inst_out
//   inst_valid_out : inst_out / inst_pc_out valid
//
// Timing: accept edge presents pc; each RDk cycle presents pc+k, and the byte
// for RDk arrives during the following cycle, so byte k is written at the
// edge ending RD(k+1) (LAST for byte 3). Valid rises 5 edges after accept.
// ----------------------------------------------------------------------------
module inst_fetch
   import riscv_defs::*;
(
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rdy_in,
   input  logic [ADDR_W-1:0]  pc_in,
   input  logic               branch_or_not,
   input  logic [STALL_W-1:0] stall_in,
   inst_fetch_if.master       mem,
   output logic               stallreq_out,
   output logic [INST_W-1:0]  inst_out,
   output logic [ADDR_W-1:0]  inst_pc_out,
   output logic               inst_valid_out
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rd_en_q, rd_en_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] ipc_q, ipc_d;
   logic              vld_q, vld_d;

   // Only the IF hold bit matters here.
   logic unused_stall;
   assign unused_stall = ^{stall_in[STALL_W-1:STALL_IF+1], stall_in[STALL_IF-1:0]};

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         fetch_pc_q <= '0;
         addr_q     <= '0;
         rd_en_q    <= 1'b0;
         inst_q     <= '0;
         ipc_q      <= '0;
         vld_q      <= 1'b0;
      end else if (rdy_in) begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         rd_en_q    <= rd_en_d;
         inst_q     <= inst_d;
         ipc_q      <= ipc_d;
         vld_q      <= vld_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      addr_d     = addr_q;
      rd_en_d    = rd_en_q;
      inst_d     = inst_q;
      ipc_d      = ipc_q;
      vld_d      = vld_q;

      case (state_q)
         IDLE: begin
            if (mem.mem_grant_in) begin
               fetch_pc_d = pc_in;
               addr_d     = pc_in;
               rd_en_d    = 1'b1;
               state_d    = RD0;
            end
         end
         RD0: begin
            addr_d  = fetch_pc_q + 32'd1;
            state_d = RD1;
         end
         RD1: begin
            inst_d[7:0] = mem.mem_din_in;
            addr_d      = fetch_pc_q + 32'd2;
            state_d     = RD2;
         end
         RD2: begin
            inst_d[15:8] = mem.mem_din_in;
            addr_d       = fetch_pc_q + 32'd3;
            state_d      = RD3;
         end
         RD3: begin
            inst_d[23:16] = mem.mem_din_in;
            rd_en_d       = 1'b0;
            state_d       = LAST;
         end
         LAST: begin
            inst_d[31:24] = mem.mem_din_in;
            ipc_d         = fetch_pc_q;
            vld_d         = 1'b1;
            state_d       = HOLD;
         end
         HOLD: begin
            if (!stall_in[STALL_IF]) begin
               vld_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            rd_en_d = 1'b0;
            vld_d   = 1'b0;
            state_d = IDLE;
         end
      endcase

      // Redirect beats everything, including consuming a held instruction;
      // going to IDLE also drops the byte still in flight.
      if (branch_or_not) begin
         state_d = IDLE;
         rd_en_d = 1'b0;
         vld_d   = 1'b0;
         inst_d  = '0;
      end
   end

   // Combinational so the PC stops advancing in the same cycle HOLD begins.
   assign stallreq_out      = (state_q != HOLD);

   assign mem.mem_a_out     = addr_q;
   assign mem.mem_rd_en_out = rd_en_q;
   assign inst_out          = inst_q;
   assign inst_pc_out       = ipc_q;
   assign inst_valid_out    = vld_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
   import riscv_defs::*;

   logic              clk_in = 1'b0;
   logic              rst_in;
   logic              rdy_in;
   logic [31:0]       pc_in;
   logic              branch_or_not;
   logic [5:0]        stall_in;
   logic              stallreq_out;
   logic [31:0]       inst_out;
   logic [31:0]       inst_pc_out;
   logic              inst_valid_out;

   int total = 0;
   int bad   = 0;

   inst_fetch_if mif();

   inst_fetch dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .pc_in          (pc_in),
      .branch_or_not  (branch_or_not),
      .stall_in       (stall_in),
      .mem            (mif),
      .stallreq_out   (stallreq_out),
      .inst_out       (inst_out),
      .inst_pc_out    (inst_pc_out),
      .inst_valid_out (inst_valid_out)
   );

   always #5 clk_in = ~clk_in;

   // RAM contents: 13 05 10 00 at 0..3, elsewhere low address byte + 0x40.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'h0:   mem_byte = 8'h13;
         32'h1:   mem_byte = 8'h05;
         32'h2:   mem_byte = 8'h10;
         32'h3:   mem_byte = 8'h00;
         default: mem_byte = a[7:0] + 8'h40;
      endcase
   endfunction

   // One-cycle read latency; frozen with the rest of the system when rdy_in=0.
   always @(posedge clk_in) begin
      if (rst_in) mif.mem_din_in <= 8'h00;
      else if (rdy_in && mif.mem_rd_en_out) mif.mem_din_in <= mem_byte(mif.mem_a_out);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // Starts in IDLE; ends in HOLD with the instruction presented.
   task automatic do_fetch(input string tag, input logic [31:0] pc, input logic [31:0] exp_inst);
      pc_in = pc;
      mif.mem_grant_in = 1'b1;
      step();
      mif.mem_grant_in = 1'b0;
      chk({tag, " a0"}, mif.mem_a_out, pc);
      chk({tag, " rd0"}, {31'd0, mif.mem_rd_en_out}, 32'd1);
      for (int k = 1; k < 4; k++) begin
         step();
         chk({tag, " ak"}, mif.mem_a_out, pc + k);
         chk({tag, " rdk"}, {31'd0, mif.mem_rd_en_out}, 32'd1);
      end
      step();
      chk({tag, " last rd"}, {31'd0, mif.mem_rd_en_out}, 32'd0);
      chk({tag, " last vld"}, {31'd0, inst_valid_out}, 32'd0);
      chk({tag, " last sreq"}, {31'd0, stallreq_out}, 32'd1);
      step();
      chk({tag, " vld"}, {31'd0, inst_valid_out}, 32'd1);
      chk({tag, " inst"}, inst_out, exp_inst);
      chk({tag, " ipc"}, inst_pc_out, pc);
      chk({tag, " hold sreq"}, {31'd0, stallreq_out}, 32'd0);
   endtask

   task automatic consume(input string tag);
      stall_in = 6'd0;
      step();
      chk({tag, " consumed"}, {31'd0, inst_valid_out}, 32'd0);
      chk({tag, " idle sreq"}, {31'd0, stallreq_out}, 32'd1);
   endtask

   initial begin
      rst_in = 1'b1;
      rdy_in = 1'b0;
      pc_in = 32'h0;
      branch_or_not = 1'b0;
      stall_in = 6'd0;
      mif.mem_grant_in = 1'b1;

      // reset applies even with rdy_in low
      step();
      step();
      chk("rst a", mif.mem_a_out, 32'h0);
      chk("rst rd", {31'd0, mif.mem_rd_en_out}, 32'd0);
      chk("rst inst", inst_out, 32'h0);
      chk("rst ipc", inst_pc_out, 32'h0);
      chk("rst vld", {31'd0, inst_valid_out}, 32'd0);
      chk("rst sreq", {31'd0, stallreq_out}, 32'd1);
      rdy_in = 1'b1;
      mif.mem_grant_in = 1'b0;
      rst_in = 1'b0;

      // no grant in IDLE: no request
      step();
      step();
      chk("nogrant rd", {31'd0, mif.mem_rd_en_out}, 32'd0);
      chk("nogrant sreq", {31'd0, stallreq_out}, 32'd1);
      chk("nogrant vld", {31'd0, inst_valid_out}, 32'd0);

      // basic fetch, immediate consume
      do_fetch("basic", 32'h0, 32'h00100513);
      consume("basic");
      step();
      chk("basic idle rd", {31'd0, mif.mem_rd_en_out}, 32'd0);

      // stalled hold for 3 cycles: valid high for 4 cycles total
      do_fetch("stall", 32'h0, 32'h00100513);
      stall_in = 6'b000010;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall vld", {31'd0, inst_valid_out}, 32'd1);
         chk("stall inst", inst_out, 32'h00100513);
         chk("stall sreq", {31'd0, stallreq_out}, 32'd0);
      end
      consume("stall");
      step();
      chk("stall once", {31'd0, inst_valid_out}, 32'd0);

      // branch in RD2
      pc_in = 32'h100;
      mif.mem_grant_in = 1'b1;
      step();
      mif.mem_grant_in = 1'b0;
      step();
      step();
      chk("br rd2 a", mif.mem_a_out, 32'h102);
      branch_or_not = 1'b1;
      step();
      branch_or_not = 1'b0;
      chk("br rd", {31'd0, mif.mem_rd_en_out}, 32'd0);
      chk("br vld", {31'd0, inst_valid_out}, 32'd0);
      chk("br sreq", {31'd0, stallreq_out}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("br novld", {31'd0, inst_valid_out}, 32'd0);
      end
      do_fetch("after br", 32'h100, 32'h43424140);
      consume("after br");

      // rdy_in low for 2 cycles while in RD1
      pc_in = 32'h0;
      mif.mem_grant_in = 1'b1;
      step();
      mif.mem_grant_in = 1'b0;
      step();
      chk("frz rd1 a", mif.mem_a_out, 32'h1);
      rdy_in = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("frz a", mif.mem_a_out, 32'h1);
         chk("frz rd", {31'd0, mif.mem_rd_en_out}, 32'd1);
      end
      rdy_in = 1'b1;
      step();
      chk("frz a2", mif.mem_a_out, 32'h2);
      step();
      chk("frz a3", mif.mem_a_out, 32'h3);
      step();
      chk("frz last vld", {31'd0, inst_valid_out}, 32'd0);
      step();
      chk("frz vld", {31'd0, inst_valid_out}, 32'd1);
      chk("frz inst", inst_out, 32'h00100513);
      consume("frz");

      // address wrap
      do_fetch("wrap", 32'hFFFF_FFFE, 32'h05133F3E);
      consume("wrap");

      // reset while in LAST
      pc_in = 32'h100;
      mif.mem_grant_in = 1'b1;
      step();
      mif.mem_grant_in = 1'b0;
      for (int i = 0; i < 4; i++) step();
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
      chk("rstl a", mif.mem_a_out, 32'h0);
      chk("rstl rd", {31'd0, mif.mem_rd_en_out}, 32'd0);
      chk("rstl inst", inst_out, 32'h0);
      chk("rstl ipc", inst_pc_out, 32'h0);
      chk("rstl vld", {31'd0, inst_valid_out}, 32'd0);
      chk("rstl sreq", {31'd0, stallreq_out}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rstl novld", {31'd0, inst_valid_out}, 32'd0);
      end
      do_fetch("post rst", 32'h0, 32'h00100513);
      consume("post rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
